usr_input_cond: RTL
===================

# usr_input_cond

Input-side conditioner for the board's user keys and switches. It turns raw, bouncing, asynchronous `usr_key_i`/`usr_sw_i` pins into clean, synchronous debounced levels and one-cycle event pulses (press, release, long-press, switch change) that downstream logic consumes. The LED status path is the other end: it shows state to the user, and this block reads the user's input into the fabric. It sits between the top-level pins and any control logic clocked by `fpga_clk_50`.

## Interface
- `DB_CYCLES`, 1_000_000: debounce window in clocks (20 ms at 50 MHz); legal ≥ 2.
- `LONG_CYCLES`, 50_000_000: hold time for a long-press event (1 s); legal ≥ 2.
- `N_KEY`, 3: number of keys.
- `N_SW`, 3: number of switches.

- `fpga_clk_50`  in  1  system clock, 50 MHz; the only clock.
- `fpga_rst_n`  in  1  asynchronous, active-low reset.
- `usr_key_i`  in  N_KEY  raw keys, low-active (0 = pressed), asynchronous.
- `usr_sw_i`  in  N_SW  raw switches, high-active, asynchronous.
- `key_level_o`  out  N_KEY  debounced key state, 1 = pressed.
- `key_press_o`  out  N_KEY  one-cycle pulse on debounced press.
- `key_release_o`  out  N_KEY  one-cycle pulse on debounced release.
- `key_long_o`  out  N_KEY  one-cycle pulse when a hold reaches LONG_CYCLES.
- `sw_level_o`  out  N_SW  debounced switch level.
- `sw_change_o`  out  N_SW  one-cycle pulse on either debounced switch edge.

## Operation
- Each bit is handled by its own independent channel. The channel has a 2-flop synchronizer, then an FSM, a debounce counter, and (for keys only) a long counter.
- Key inputs are inverted after synchronizing, so internal "active" = 1.
- FSM states and transitions:
  - IDLE (level 0) → PRESS_WAIT when the synced input is active; debounce counter cleared.
  - PRESS_WAIT: input inactive → IDLE with no output. Otherwise, when the counter equals DB_CYCLES-1 → PRESSED, level goes to 1 and the press pulse fires. Otherwise the counter increments.
  - PRESSED: the long counter increments. When it equals LONG_CYCLES-1 it fires the long pulse once and then saturates. Input inactive → RELEASE_WAIT with the debounce counter cleared.
  - RELEASE_WAIT: input active → PRESSED with no pulse; the long counter holds its value and does not reset. Otherwise, when the counter equals DB_CYCLES-1 → IDLE, level goes to 0, the release pulse fires and the long counter is cleared.
- Switch channels use the same FSM with the long path disabled. `sw_change_o` = press OR release pulse.
- Counter widths are $clog2 of their terminal value. Counters never wrap.
- Simultaneous events on different channels are independent and may pulse in the same cycle.

## Timing
- Reset (asynchronous, any time): all FSMs go to IDLE, counters to 0, and every output to 0.
  - Key synchronizer flops reset to 1 (released). Switch synchronizer flops reset to 0.
  - No pulses are emitted because of reset, either on assertion or on release.
- Latency: if the raw pin is first sampled changed at edge k, the level output changes and the pulse fires after edge k+2+DB_CYCLES. The pulse lasts exactly one cycle.
- Glitch rejection:
  - An input change lasting ≤ DB_CYCLES clocks produces no output.
  - A change lasting ≥ DB_CYCLES+1 clocks is accepted.
- Long press: `key_long_o` fires LONG_CYCLES cycles after `key_press_o`. Time spent in RELEASE_WAIT bounces does not count toward the hold. At most one long pulse per press.
- A switch held at 1 through reset produces `sw_level_o`=1 and one `sw_change_o` pulse DB_CYCLES+2 cycles after reset release.

## Structure
- Package `usr_io_pkg` holds:
  - the channel state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default constants: DB_CYCLES_50M = 1_000_000 and LONG_CYCLES_50M = 50_000_000.
- Sub-module `usr_debounce_chan`:
  - parameters DB_CYCLES, LONG_CYCLES, LONG_EN, ACTIVE_LOW, SYNC_RST_VAL;
  - instantiated N_KEY + N_SW times from generate loops in `usr_input_cond`.

## Test plan
All scenarios use DB_CYCLES=4 and LONG_CYCLES=16.
- **Switch through reset:** hold reset with `usr_sw_i`=3'b101 and keys=3'b111 → all outputs 0 during reset. 6 cycles after release, `sw_level_o`=3'b101 and `sw_change_o`=3'b101 for one cycle. Key outputs stay 0.
- **Glitch filter:** `usr_key_i[0]`=0 for 4 clocks → no output. `usr_key_i[0]`=0 held → `key_press_o[0]` pulses 6 cycles after the first sampled low, and `key_level_o[0]`=1.
- **Long press:** hold key 1 → `key_long_o[1]` pulses exactly 16 cycles after `key_press_o[1]`, only once over a 40-cycle hold. Release → one `key_release_o[1]`, 6 cycles after the raw release.
- **Release bounce:** on key 2 release, raw goes 1 for 2 cycles, back to 0 for 3, then 1 steady → `key_level_o[2]` stays 1 through the bounce, then exactly one `key_release_o[2]`. No extra press pulse.
- **Simultaneous press:** `usr_key_i` goes 3'b111→3'b000 on one edge → `key_press_o`=3'b111 in a single cycle.
- **Reset mid-hold:** assert `fpga_rst_n`=0 while key 0 is PRESSED → `key_level_o` drops to 0 without waiting for a clock edge. After reset release with the key still held, a fresh press pulse appears 6 cycles later. No release or long pulse fires.

Source files
------------

// File: rtl/usr_io_pkg.sv
// Shared types and constants for the user key/switch input conditioner.
package usr_io_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } chan_state_e;

    // Default windows for a 50 MHz clock: 20 ms debounce, 1 s long press.
    localparam int DB_CYCLES_50M   = 32'd1_000_000;
    localparam int LONG_CYCLES_50M = 32'd50_000_000;

    // Counter width needed to reach terminal-1; never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal < 32'sd2) ? 32'sd1 : $clog2(terminal);
    endfunction

endpackage

// File: rtl/usr_debounce_chan.sv
// One input channel: 2-flop synchronizer, debounce FSM and optional
// long-press timer. All outputs are driven straight from flops.
module usr_debounce_chan
    import usr_io_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_50M,
    parameter int LONG_CYCLES  = LONG_CYCLES_50M,
    parameter bit LONG_EN      = 1'b1,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit SYNC_RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse_press,
    output logic pulse_rel,
    output logic pulse_long
);

    localparam int DB_W   = cnt_width(DB_CYCLES);
    localparam int LONG_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [1:0]        sync_r;
    logic              active_s;
    chan_state_e       state_r,     state_s;
    logic [DB_W-1:0]   db_cnt_r,    db_cnt_s;
    logic [LONG_W-1:0] long_cnt_r,  long_cnt_s;
    logic              long_done_r, long_done_s;
    logic              level_r,     level_s;
    logic              press_r,     press_s;
    logic              rel_r,       rel_s;
    logic              long_r,      long_s;

    // Two-flop synchronizer; resets to the pin's idle level so reset never
    // looks like an input edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {2{SYNC_RST_VAL}};
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Internal polarity: 1 means the user is actuating the input.
    assign active_s = ACTIVE_LOW ? ~sync_r[1] : sync_r[1];

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            db_cnt_r    <= '0;
            long_cnt_r  <= '0;
            long_done_r <= 1'b0;
            level_r     <= 1'b0;
            press_r     <= 1'b0;
            rel_r       <= 1'b0;
            long_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            db_cnt_r    <= db_cnt_s;
            long_cnt_r  <= long_cnt_s;
            long_done_r <= long_done_s;
            level_r     <= level_s;
            press_r     <= press_s;
            rel_r       <= rel_s;
            long_r      <= long_s;
        end
    end

    // Next-state logic; pulses default low so each fires for one cycle only.
    always_comb begin
        state_s     = state_r;
        db_cnt_s    = db_cnt_r;
        long_cnt_s  = long_cnt_r;
        long_done_s = long_done_r;
        level_s     = level_r;
        press_s     = 1'b0;
        rel_s       = 1'b0;
        long_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (active_s) begin
                    state_s  = ST_PRESS_WAIT;
                    db_cnt_s = '0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_PRESS_WAIT: begin
                if (!active_s) begin
                    state_s = ST_IDLE;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s = ST_PRESSED;
                    level_s = 1'b1;
                    press_s = 1'b1;
                end else begin
                    db_cnt_s = db_cnt_r + DB_W'(1);
                end
            end

            ST_PRESSED: begin
                // Long timer saturates at its terminal value; the done flag
                // limits it to one pulse per press.
                if (LONG_EN && !long_done_r) begin
                    if (long_cnt_r == LONG_LAST) begin
                        long_s      = 1'b1;
                        long_done_s = 1'b1;
                    end else begin
                        long_cnt_s  = long_cnt_r + LONG_W'(1);
                    end
                end else begin
                    long_cnt_s = long_cnt_r;
                end
                if (!active_s) begin
                    state_s  = ST_RELEASE_WAIT;
                    db_cnt_s = '0;
                end else begin
                    state_s  = ST_PRESSED;
                end
            end

            ST_RELEASE_WAIT: begin
                // A bounce back to active resumes the hold; the long timer
                // keeps its value rather than restarting.
                if (active_s) begin
                    state_s = ST_PRESSED;
                end else if (db_cnt_r == DB_LAST) begin
                    state_s     = ST_IDLE;
                    level_s     = 1'b0;
                    rel_s       = 1'b1;
                    long_cnt_s  = '0;
                    long_done_s = 1'b0;
                end else begin
                    db_cnt_s = db_cnt_r + DB_W'(1);
                end
            end

            default: begin
                state_s     = ST_IDLE;
                db_cnt_s    = '0;
                long_cnt_s  = '0;
                long_done_s = 1'b0;
                level_s     = 1'b0;
            end
        endcase
    end

    assign level       = level_r;
    assign pulse_press = press_r;
    assign pulse_rel   = rel_r;
    assign pulse_long  = long_r;

endmodule

// File: rtl/usr_input_cond.sv
// User key/switch conditioner: one independent debounce channel per pin.
module usr_input_cond
    import usr_io_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50M,
    parameter int LONG_CYCLES = LONG_CYCLES_50M,
    parameter int N_KEY       = 3,
    parameter int N_SW        = 3
) (
    input  logic             fpga_clk_50,
    input  logic             fpga_rst_n,
    input  logic [N_KEY-1:0] usr_key_i,
    input  logic [N_SW-1:0]  usr_sw_i,
    output logic [N_KEY-1:0] key_level_o,
    output logic [N_KEY-1:0] key_press_o,
    output logic [N_KEY-1:0] key_release_o,
    output logic [N_KEY-1:0] key_long_o,
    output logic [N_SW-1:0]  sw_level_o,
    output logic [N_SW-1:0]  sw_change_o
);

    logic [N_SW-1:0] sw_press_s;
    logic [N_SW-1:0] sw_rel_s;
    logic [N_SW-1:0] sw_long_s;

    // Keys: low-active pins, synchronizers idle high, long-press enabled.
    for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
        usr_debounce_chan #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_EN     (1'b1),
            .ACTIVE_LOW  (1'b1),
            .SYNC_RST_VAL(1'b1)
        ) u_chan (
            .clk        (fpga_clk_50),
            .rst_n      (fpga_rst_n),
            .raw        (usr_key_i[gi]),
            .level      (key_level_o[gi]),
            .pulse_press(key_press_o[gi]),
            .pulse_rel  (key_release_o[gi]),
            .pulse_long (key_long_o[gi])
        );
    end

    // Switches: high-active pins, synchronizers idle low, no long timer.
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        usr_debounce_chan #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_EN     (1'b0),
            .ACTIVE_LOW  (1'b0),
            .SYNC_RST_VAL(1'b0)
        ) u_chan (
            .clk        (fpga_clk_50),
            .rst_n      (fpga_rst_n),
            .raw        (usr_sw_i[gi]),
            .level      (sw_level_o[gi]),
            .pulse_press(sw_press_s[gi]),
            .pulse_rel  (sw_rel_s[gi]),
            .pulse_long (sw_long_s[gi])
        );
    end

    // Either debounced edge is a change. The long pulse is held at zero in
    // switch channels, so folding it in never adds an event.
    assign sw_change_o = sw_press_s | sw_rel_s | sw_long_s;

endmodule
